// File: rtl/uart_cdc_bus_tx.sv
// uart_cdc_bus_tx: source end of a 4-phase req/ack word crossing between clock domains.
//   i_clk/i_nrst         clock, asynchronous active-low reset
//   i_valid/o_ready      upstream handshake (o_ready high only in IDLE)
//   i_data               upstream word, captured on the accept edge
//   o_cdc_data           launch register, stable for the whole req/ack cycle
//   o_cdc_req            level request, straight from a flop
//   i_cdc_ack            acknowledge from the destination domain (asynchronous)
//   o_done               one-cycle pulse when a transfer completes
module uart_cdc_bus_tx #(
  parameter int BUS_WIDTH    = 32,
  parameter int CDC_STAGES   = 2,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_nrst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [BUS_WIDTH-1:0] i_data,
  output logic [BUS_WIDTH-1:0] o_cdc_data,
  output logic                 o_cdc_req,
  input  logic                 i_cdc_ack,
  output logic                 o_done
);
  localparam int CW = SETUP_CYCLES > 1 ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETUP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_e;
  state_e                state_q, state_d;
  logic [CDC_STAGES-1:0] ack_sync_q;
  logic                  ack_s;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  req_q, req_d, done_q, done_d;
  assign ack_s      = ack_sync_q[CDC_STAGES-1];
  assign o_ready    = state_q == IDLE;
  assign o_cdc_data = data_q;
  assign o_cdc_req  = req_q;
  assign o_done     = done_q;
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q    <= IDLE;
      ack_sync_q <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= {ack_sync_q[CDC_STAGES-2:0], i_cdc_ack};
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      req_q      <= req_d;
      done_q     <= done_d;
    end
  end
  // The counter saturates at its last value, so a stale ack simply parks
  // the FSM in SETUP until the synchronized ack has returned low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (i_valid) begin
        data_d  = i_data;
        cnt_d   = '0;
        state_d = SETUP;
      end
      SETUP: if (cnt_q != CNT_LAST) cnt_d = cnt_q + CW'(1);
        else if (!ack_s) begin
          req_d   = 1'b1;
          state_d = REQ_HI;
        end
      REQ_HI: if (ack_s) begin
        req_d   = 1'b0;
        state_d = REQ_LO;
      end
      REQ_LO: if (!ack_s) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
